// File: rtl/axil_regbank_v2.sv
// axil_regbank_v2: AXI4-Lite slave exposing NUM_REGS read/write registers.
// Write path accepts AW and W independently (either order, any gap), commits
// once both are present, and answers with OKAY or SLVERR (index out of range).
// Read path returns the register or zero/SLVERR one cycle after the AR handshake.
// Optional macro AXIL_REGBANK_WPULSE_EN enables the per-register wr_pulse output;
// without it wr_pulse is tied low.
module axil_regbank_v2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
    localparam int IW       = ADDR_WIDTH - ADDR_LSB;
    localparam int NB       = DATA_WIDTH/8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic          aw_held, w_held, bvalid_q, rvalid_q;
    logic [IW-1:0] aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-offset address bits carry no information for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    assign AWREADY = !aw_held && !bvalid_q;
    assign WREADY  = !w_held && !bvalid_q;
    assign ARREADY = !rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    // A value arriving this cycle is used directly so a same-cycle AW+W commits at once.
    logic [IW-1:0]         wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;
    assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_held ? w_data_q : WDATA;
    assign wr_strb = w_held ? w_strb_q : WSTRB;
    assign rd_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    // Decode both indices; a miss on every register means out of range.
    logic                  wr_hit, rd_hit;
    logic [DATA_WIDTH-1:0] rd_val;
    always_comb begin
        wr_hit = 1'b0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IW'(i)) wr_hit = 1'b1;
            if (rd_idx == IW'(i)) begin
                rd_hit = 1'b1;
                rd_val = regs[i];
            end
        end
    end

    // Register file: strobed byte update on commit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_idx == IW'(i))
                    for (int b = 0; b < NB; b++)
                        if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Write channel: hold AW/W until both are present, then raise B until BREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (bvalid_q && BREADY) bvalid_q <= 1'b0;
        end
    end

    // Read channel: data captured at the AR handshake, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

`ifdef AXIL_REGBANK_WPULSE_EN
    logic [NUM_REGS-1:0] pulse_q;
    // One-cycle strobe aligned with BVALID rising, for in-range writes only.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            if (commit)
                for (int i = 0; i < NUM_REGS; i++)
                    if (wr_idx == IW'(i)) pulse_q[i] <= 1'b1;
        end
    end
    assign wr_pulse = pulse_q;
`else
    assign wr_pulse = '0;
`endif

endmodule

// File: tb/tb_axil_regbank_v2.sv
// Directed bench for axil_regbank_v2 with a transaction-level model:
// AW/W handshakes are queued and paired, the paired write is applied to a
// model register array, and expected B/R/reg_q/wr_pulse are checked every cycle.
module tb_axil_regbank_v2;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 4;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [AW-1:0] AWADDR = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [DW-1:0] WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b1;
    logic [AW-1:0] ARADDR = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY = 1'b1;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    wr_pulse;

    axil_regbank_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE('0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [DW-1:0] m_regs [NR];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] wd_q [$];
    logic [3:0]    ws_q [$];
    bit            exp_bv, exp_rv;
    logic [1:0]    exp_bresp, exp_rresp;
    logic [DW-1:0] exp_rdata;
    logic [NR-1:0] exp_pulse;

    function automatic logic [NR*DW-1:0] m_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
        return f;
    endfunction

    // Single compare process: check this cycle against the model, then advance it.
    always @(negedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            aw_q.delete(); wd_q.delete(); ws_q.delete();
            exp_bv = 0; exp_rv = 0; exp_pulse = '0;
            exp_bresp = 2'b00; exp_rresp = 2'b00; exp_rdata = '0;
            chk("rst_reg_q", reg_q, '0);
            chk("rst_bvalid", BVALID, 1'b0);
            chk("rst_rvalid", RVALID, 1'b0);
            chk("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
            chk("rst_resp_data", {BRESP, RRESP, RDATA}, '0);
            chk("rst_wr_pulse", wr_pulse, '0);
        end else begin
            int idx;
            chk("reg_q", reg_q, m_flat());
            chk("bvalid", BVALID, exp_bv);
            if (exp_bv) begin
                chk("bresp", BRESP, exp_bresp);
                chk("aw_w_ready_during_b", {AWREADY, WREADY}, 2'b00);
            end
            chk("rvalid", RVALID, exp_rv);
            chk("arready", ARREADY, !exp_rv);
            if (exp_rv) begin
                chk("rdata", RDATA, exp_rdata);
                chk("rresp", RRESP, exp_rresp);
            end
            chk("wr_pulse", wr_pulse, exp_pulse);
            exp_pulse = '0;
            if (exp_bv && BREADY) exp_bv = 0;
            if (exp_rv && RREADY) exp_rv = 0;
            // Read sees the register contents before any write taking effect this edge.
            if (ARVALID && ARREADY) begin
                idx = int'(ARADDR) / 4;
                exp_rv = 1;
                exp_rdata = (idx < NR) ? m_regs[idx] : '0;
                exp_rresp = (idx < NR) ? 2'b00 : 2'b10;
            end
            if (AWVALID && AWREADY) aw_q.push_back(AWADDR);
            if (WVALID && WREADY) begin
                wd_q.push_back(WDATA);
                ws_q.push_back(WSTRB);
            end
            if (aw_q.size() > 0 && wd_q.size() > 0) begin
                logic [DW-1:0] d;
                logic [3:0]    s;
                idx = int'(aw_q.pop_front()) / 4;
                d = wd_q.pop_front();
                s = ws_q.pop_front();
                exp_bv = 1;
                exp_bresp = (idx < NR) ? 2'b00 : 2'b10;
                if (idx < NR) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
`ifdef AXIL_REGBANK_WPULSE_EN
                    exp_pulse[idx] = 1'b1;
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0;
        int n = 0;
        @(posedge ACLK); #1;
        AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            @(posedge ACLK); #1;
            if (aw_done) AWVALID = 0;
            if (w_done) WVALID = 0;
            n++;
        end
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_b(output logic [1:0] r);
        bit got = 0;
        int n = 0;
        r = 2'b11;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (BVALID && BREADY) begin got = 1; r = BRESP; end
            @(posedge ACLK); #1;
            n++;
        end
        chk("b_timeout", got, 1'b1);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        bit fired = 0, got = 0;
        int n = 0;
        d = '0; r = 2'b11;
        @(posedge ACLK); #1;
        ARADDR = a; ARVALID = 1;
        while (!fired && n < 20) begin
            @(negedge ACLK);
            if (ARVALID && ARREADY) fired = 1;
            @(posedge ACLK); #1;
            if (fired) ARVALID = 0;
            n++;
        end
        n = 0;
        while (!got && n < 20) begin
            @(negedge ACLK);
            if (RVALID) begin got = 1; d = RDATA; r = RRESP; end
            @(posedge ACLK); #1;
            n++;
        end
        chk("rd_done", {fired, got}, 2'b11);
    endtask

    initial begin
        logic [DW-1:0]    d;
        logic [1:0]       r;
        logic [NR*DW-1:0] snap;
        logic [NR-1:0]    p_exp;

        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;

        // Four word writes then read-back.
        for (int i = 0; i < 4; i++) begin
            wr(AW'(i*4), DW'(i+1), 4'hF);
            wait_b(r);
            chk("wr_seq_bresp", r, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            rd(AW'(i*4), d, r);
            chk("rd_seq_data", d, DW'(i+1));
            chk("rd_seq_rresp", r, 2'b00);
        end
        chk("reg_q_seq", reg_q, 128'h00000004_00000003_00000002_00000001);

        // Byte strobes.
        wr(6'h00, 32'hAABBCCDD, 4'hF); wait_b(r);
        wr(6'h00, 32'h11223344, 4'b0101); wait_b(r);
        rd(6'h00, d, r);
        chk("strobe_rdata", d, 32'hAA22CC44);

        // W first, AW three cycles later.
        @(posedge ACLK); #1;
        WDATA = 32'h5A5A0001; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        chk("wfirst_w_accept", WREADY, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge ACLK); #1;
            WVALID = 0;
            if (c == 3) begin AWADDR = 6'h04; AWVALID = 1; end
            @(negedge ACLK);
            chk("wfirst_wready_low", WREADY, 1'b0);
            chk("wfirst_no_b_yet", BVALID, 1'b0);
        end
        @(posedge ACLK); #1;
        AWVALID = 0;
        @(negedge ACLK);
        chk("wfirst_bvalid_c4", BVALID, 1'b1);
        chk("wfirst_reg1", reg_q[63:32], 32'h5A5A0001);
        @(posedge ACLK); #1;

        // Out-of-range write and read.
        snap = reg_q;
        wr(6'h10, 32'hDEADBEEF, 4'hF); wait_b(r);
        chk("oor_bresp", r, 2'b10);
        chk("oor_reg_q_same", reg_q, snap);
        rd(6'h10, d, r);
        chk("oor_rdata", d, 32'h0);
        chk("oor_rresp", r, 2'b10);

        // Backpressure on B; write to reg 2.
        BREADY = 0;
        wr(6'h08, 32'hCAFEF00D, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("bhold_bvalid", BVALID, 1'b1);
            chk("bhold_readies", {AWREADY, WREADY}, 2'b00);
`ifdef AXIL_REGBANK_WPULSE_EN
            p_exp = (k == 0) ? 4'b0100 : 4'b0000;
`else
            p_exp = 4'b0000;
`endif
            chk("bhold_pulse", wr_pulse, p_exp);
            @(posedge ACLK); #1;
        end
        BREADY = 1;
        wait_b(r);
        chk("bhold_bresp", r, 2'b00);

        // Zero strobe: OKAY, no change.
        snap = reg_q;
        wr(6'h04, 32'hFFFFFFFF, 4'h0); wait_b(r);
        chk("wstrb0_bresp", r, 2'b00);
        chk("wstrb0_same", reg_q, snap);

        // Read and write to reg 3 in the same cycle: read returns old value.
        @(posedge ACLK); #1;
        AWADDR = 6'h0C; AWVALID = 1; WDATA = 32'h77778888; WSTRB = 4'hF; WVALID = 1;
        ARADDR = 6'h0C; ARVALID = 1;
        @(negedge ACLK);
        chk("simul_accept", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        @(negedge ACLK);
        chk("simul_rdata_old", RDATA, 32'h00000004);
        chk("simul_reg3_new", reg_q[127:96], 32'h77778888);
        @(posedge ACLK); #1;

        // Reset between AW and W.
        @(posedge ACLK); #1;
        AWADDR = 6'h00; AWVALID = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        AWVALID = 0;
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        WVALID = 0;
        repeat (2) begin
            @(negedge ACLK);
            chk("rst_mid_no_b", BVALID, 1'b0);
            chk("rst_mid_regs", reg_q, '0);
            @(posedge ACLK); #1;
        end
        AWADDR = 6'h00; AWVALID = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        AWVALID = 0;
        wait_b(r);
        chk("rst_mid_bresp", r, 2'b00);
        wr(6'h08, 32'h0BADC0DE, 4'hF); wait_b(r);
        rd(6'h08, d, r);
        chk("post_rst_rdata", d, 32'h0BADC0DE);
        rd(6'h00, d, r);
        chk("post_rst_w_then_aw", d, 32'h12345678);

        repeat (3) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
